// File: rtl/snn_run_ctrl_if.sv
// snn_run_ctrl_if
//  Control/status bundle between the run sequencer and its neighbours
//  (config registers, spike generator, IF network).
//  master : the side that issues start/abort/config and supplies network spikes
//  slave  : the run sequencer itself
//  Signals
//   start, abort          run control requests
//   timesteps, input_mask run configuration, sampled on an accepted start
//   spike_out             output spikes from the network, one bit per output neuron
//   spike_en              input spike enables to the spike generator
//   net_clr               network membrane/refractory clear
//   busy, done            run status; done is a 1-cycle completion pulse
//   spike_count, winner   per-output spike counts (output i at [i*CNT_WIDTH +: CNT_WIDTH])
//                         and index of the output with the highest count
interface snn_run_ctrl_if #(
   parameter int NUM_INPUTS  = 4,
   parameter int NUM_OUTPUTS = 1,
   parameter int CNT_WIDTH   = 16,
   parameter int WIN_WIDTH   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
);
   logic                             start;
   logic                             abort;
   logic [CNT_WIDTH-1:0]             timesteps;
   logic [NUM_INPUTS-1:0]            input_mask;
   logic [NUM_OUTPUTS-1:0]           spike_out;
   logic [NUM_INPUTS-1:0]            spike_en;
   logic                             net_clr;
   logic                             busy;
   logic                             done;
   logic [NUM_OUTPUTS*CNT_WIDTH-1:0] spike_count;
   logic [WIN_WIDTH-1:0]             winner;

   modport master (
      output start, abort, timesteps, input_mask, spike_out,
      input  spike_en, net_clr, busy, done, spike_count, winner
   );

   modport slave (
      input  start, abort, timesteps, input_mask, spike_out,
      output spike_en, net_clr, busy, done, spike_count, winner
   );
endinterface

// File: rtl/snn_run_ctrl.sv
// snn_run_ctrl
//  Run sequencer for one SNN inference. On an accepted start it pulses the
//  network clear, enables the latched input mask for the latched number of
//  timesteps, waits DRAIN_CYCLES for in-flight spikes, then pulses done with
//  per-output spike counts and the index of the winning output.
//  Ports
//   S_AXI_ACLK     clock
//   S_AXI_ARESETN  asynchronous active-low reset
//   bus            snn_run_ctrl_if.slave (control, config, spikes, status)
//  The interface instance must be built with the same NUM_INPUTS,
//  NUM_OUTPUTS and CNT_WIDTH as this module.
module snn_run_ctrl #(
   parameter int NUM_INPUTS   = 4,
   parameter int NUM_OUTPUTS  = 1,
   parameter int CNT_WIDTH    = 16,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic           S_AXI_ACLK,
   input  logic           S_AXI_ARESETN,
   snn_run_ctrl_if.slave  bus
);
   localparam int WIN_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
   localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
   localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_CYCLES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t                           state_reg, state_next;
   logic [CNT_WIDTH-1:0]             ts_reg;
   logic [NUM_INPUTS-1:0]            mask_reg;
   logic [CNT_WIDTH-1:0]             tstep_reg, tstep_next;
   logic [DRN_W-1:0]                 drain_reg, drain_next;
   logic [NUM_INPUTS-1:0]            spike_en_reg;
   logic                             net_clr_reg;
   logic                             busy_reg;
   logic                             done_reg;
   logic [WIN_W-1:0]                 winner_reg, winner_calc;
   logic [CNT_WIDTH-1:0]             best_cnt;
   logic [NUM_OUTPUTS*CNT_WIDTH-1:0] cnt_reg_flat, cnt_next_flat;
   logic                             start_acc;
   logic                             counting;

   // start is only honoured from IDLE; in every other state busy is high
   assign start_acc = (state_reg == ST_IDLE) && bus.start;
   assign counting  = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      tstep_next = tstep_reg;
      drain_next = drain_reg;
      case (state_reg)
         ST_IDLE: begin
            if (bus.start) begin
               state_next = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (bus.abort) begin
               state_next = ST_IDLE;
            end else if (ts_reg != '0) begin
               state_next = ST_RUN;
               tstep_next = CNT_WIDTH'(1);
            end else begin
               state_next = ST_DRAIN;
               drain_next = DRN_W'(1);
            end
         end
         ST_RUN: begin
            if (bus.abort) begin
               state_next = ST_IDLE;
            end else if (tstep_reg == ts_reg) begin
               state_next = ST_DRAIN;
               drain_next = DRN_W'(1);
            end else begin
               tstep_next = tstep_reg + CNT_WIDTH'(1);
            end
         end
         ST_DRAIN: begin
            if (bus.abort) begin
               state_next = ST_IDLE;
            end else if (drain_reg == DRAIN_LAST) begin
               state_next = ST_DONE;
            end else begin
               drain_next = drain_reg + DRN_W'(1);
            end
         end
         ST_DONE: begin
            // abort is ignored here: the run completes regardless
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------- per-output saturating spike counters ----------------
   generate
      for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_cnt
         logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;

         always_comb begin
            cnt_next = cnt_reg;
            if (start_acc) begin
               cnt_next = '0;
            end else if (counting && bus.spike_out[gi] && (cnt_reg != '1)) begin
               cnt_next = cnt_reg + CNT_WIDTH'(1);
            end
         end

         always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN) begin
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_next;
            end
         end

         assign cnt_reg_flat[gi*CNT_WIDTH +: CNT_WIDTH]  = cnt_reg;
         assign cnt_next_flat[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_next;
      end
   endgenerate

   // Winner is taken from the counts as they will stand in the DONE cycle,
   // so it includes the last drain-cycle spike. Strict '>' keeps the
   // lowest index on ties and yields 0 when every count is zero.
   always_comb begin
      winner_calc = '0;
      best_cnt    = cnt_next_flat[0 +: CNT_WIDTH];
      for (int i = 1; i < NUM_OUTPUTS; i++) begin
         if (cnt_next_flat[i*CNT_WIDTH +: CNT_WIDTH] > best_cnt) begin
            best_cnt    = cnt_next_flat[i*CNT_WIDTH +: CNT_WIDTH];
            winner_calc = WIN_W'(i);
         end
      end
   end

   // ---------------- state and registered outputs ----------------
   // Outputs are decoded from state_next so they change on the same edge
   // as the state register and line up with the state they describe.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_reg    <= ST_IDLE;
         ts_reg       <= '0;
         mask_reg     <= '0;
         tstep_reg    <= '0;
         drain_reg    <= '0;
         spike_en_reg <= '0;
         net_clr_reg  <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         winner_reg   <= '0;
      end else begin
         state_reg <= state_next;
         tstep_reg <= tstep_next;
         drain_reg <= drain_next;
         if (start_acc) begin
            ts_reg   <= bus.timesteps;
            mask_reg <= bus.input_mask;
         end
         // mask_reg is already latched: RUN is always preceded by CLEAR
         spike_en_reg <= (state_next == ST_RUN) ? mask_reg : '0;
         net_clr_reg  <= (state_next == ST_CLEAR);
         busy_reg     <= (state_next != ST_IDLE);
         done_reg     <= (state_next == ST_DONE);
         if (start_acc) begin
            winner_reg <= '0;
         end else if ((state_reg == ST_DRAIN) && (state_next == ST_DONE)) begin
            winner_reg <= winner_calc;
         end
      end
   end

   assign bus.spike_en    = spike_en_reg;
   assign bus.net_clr     = net_clr_reg;
   assign bus.busy        = busy_reg;
   assign bus.done        = done_reg;
   assign bus.spike_count = cnt_reg_flat;
   assign bus.winner      = winner_reg;

endmodule

// File: tb/tb_snn_run_ctrl.sv
// tb_snn_run_ctrl
//  Directed bench for snn_run_ctrl (4 inputs, 3 outputs, 4-bit counters,
//  2 drain cycles). Each run pushes its hand-computed result into a queue;
//  a monitor pops and compares whenever done is seen.
module tb_snn_run_ctrl;
   localparam int NI = 4;
   localparam int NO = 3;
   localparam int CW = 4;
   localparam int DR = 2;
   localparam int WW = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   snn_run_ctrl_if #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .CNT_WIDTH(CW), .WIN_WIDTH(WW)) bus ();

   snn_run_ctrl #(
      .NUM_INPUTS   (NI),
      .NUM_OUTPUTS  (NO),
      .CNT_WIDTH    (CW),
      .DRAIN_CYCLES (DR)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .bus           (bus)
   );

   typedef struct {
      int            done_cyc;
      int            en_cyc;
      int            clr_cyc;
      logic [CW-1:0] c0;
      logic [CW-1:0] c1;
      logic [CW-1:0] c2;
      logic [WW-1:0] win;
   } exp_t;

   exp_t          exp_q[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   int            run_id  = 0;
   logic [NI-1:0] cur_mask = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // spike_out pattern at cycle k relative to the start cycle
   function automatic logic [NO-1:0] pat_val(input int pat, input int k);
      logic [NO-1:0] v;
      v = '0;
      case (pat)
         1: v[0] = k[0];
         2: v = '1;
         3: begin
            v[0] = (k >= 2) && (k <= 4);
            v[1] = (k >= 2) && (k <= 8);
            v[2] = (k >= 3) && (k <= 9);
         end
         4: begin
            v[0] = (k == 2);
            v[2] = 1'b1;
         end
         default: v = '0;
      endcase
      return v;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   initial begin
      int   en_n;
      int   clr_n;
      int   last_id;
      exp_t e;
      en_n    = 0;
      clr_n   = 0;
      last_id = 0;
      forever begin
         @(negedge clk);
         if (run_id != last_id) begin
            last_id = run_id;
            en_n    = 0;
            clr_n   = 0;
         end
         if (rst_n) begin
            if (bus.net_clr) clr_n++;
            if (bus.spike_en != '0) begin
               en_n++;
               chk("spike_en_mask", 32'(bus.spike_en), 32'(cur_mask));
            end
            if (bus.done) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                  chk("en_cycles", 32'(en_n), 32'(e.en_cyc));
                  chk("clr_cycles", 32'(clr_n), 32'(e.clr_cyc));
                  chk("count0", 32'(bus.spike_count[0 +: CW]), 32'(e.c0));
                  chk("count1", 32'(bus.spike_count[CW +: CW]), 32'(e.c1));
                  chk("count2", 32'(bus.spike_count[2*CW +: CW]), 32'(e.c2));
                  chk("winner", 32'(bus.winner), 32'(e.win));
                  chk("busy_in_done", 32'(bus.busy), 32'd1);
                  $display("[TB] done at cycle %0d counts=%0d,%0d,%0d winner=%0d",
                           cyc, bus.spike_count[0 +: CW], bus.spike_count[CW +: CW],
                           bus.spike_count[2*CW +: CW], bus.winner);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_run(input int t, input logic [NI-1:0] mask, input int pat,
                         input int restart_k, input bit abort0,
                         input int e0, input int e1, input int e2, input int ew);
      exp_t e;
      @(posedge clk); #1;
      run_id++;
      cur_mask        = mask;
      bus.start       = 1'b1;
      bus.abort       = abort0;
      bus.timesteps   = CW'(t);
      bus.input_mask  = mask;
      bus.spike_out   = pat_val(pat, 0);
      e.done_cyc = cyc + t + DR + 2;
      e.en_cyc   = t;
      e.clr_cyc  = 1;
      e.c0       = CW'(e0);
      e.c1       = CW'(e1);
      e.c2       = CW'(e2);
      e.win      = WW'(ew);
      exp_q.push_back(e);
      $display("[TB] start run T=%0d mask=%b pattern=%0d at cycle %0d", t, mask, pat, cyc);
      for (int k = 1; k <= t + DR + 2; k++) begin
         @(posedge clk); #1;
         // config is scrambled after start to show it was latched
         bus.start      = (k == restart_k);
         bus.abort      = 1'b0;
         bus.timesteps  = '1;
         bus.input_mask = ~mask;
         bus.spike_out  = pat_val(pat, k);
      end
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.spike_out = '0;
   endtask

   initial begin
      repeat (5000) @(posedge clk);
      $display("FAIL watchdog: got no end of test, expected finish within 5000 cycles");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.timesteps  = '0;
      bus.input_mask = '0;
      bus.spike_out  = '0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_net_clr", 32'(bus.net_clr), 32'd0);
      chk("rst_spike_en", 32'(bus.spike_en), 32'd0);
      chk("rst_counts", 32'(bus.spike_count), 32'd0);
      chk("rst_winner", 32'(bus.winner), 32'd0);
      $display("[TB] reset state checked");
      @(negedge clk);
      rst_n = 1'b1;

      // basic: spike on odd cycles, counted over cycles 2..13 -> 6
      do_run(10, 4'b0101, 1, 0, 0, 6, 0, 0, 0);
      // zero timesteps, no spikes
      do_run(0, 4'b1111, 0, 0, 0, 0, 0, 0, 0);
      // counts 3,7,7 -> tie goes to index 1; a start during busy is ignored
      do_run(6, 4'b0011, 3, 3, 0, 3, 7, 7, 1);
      // clear winner at index 2
      do_run(3, 4'b1000, 4, 0, 0, 1, 0, 5, 2);
      // saturation: 17 counted spikes on each output clip at 15
      do_run(15, 4'b0110, 2, 0, 0, 15, 15, 15, 0);
      bus.spike_out = '1;
      repeat (3) @(posedge clk);
      #1;
      bus.spike_out = '0;
      chk("hold_count0", 32'(bus.spike_count[0 +: CW]), 32'd15);
      chk("hold_count2", 32'(bus.spike_count[2*CW +: CW]), 32'd15);
      chk("hold_winner", 32'(bus.winner), 32'd0);
      chk("hold_busy", 32'(bus.busy), 32'd0);
      $display("[TB] hold after saturation checked");
      // start with abort in IDLE: start wins; spikes only during the two drain cycles
      do_run(0, 4'b0001, 2, 0, 1, 2, 2, 2, 0);

      // abort during the 5th RUN cycle (k=6); spikes counted at k=3,5
      @(posedge clk); #1;
      run_id++;
      cur_mask       = 4'b1010;
      bus.start      = 1'b1;
      bus.timesteps  = CW'(10);
      bus.input_mask = 4'b1010;
      bus.spike_out  = pat_val(1, 0);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         bus.start     = 1'b0;
         bus.spike_out = pat_val(1, k);
         bus.abort     = (k == 6);
      end
      @(posedge clk); #1;
      bus.abort     = 1'b0;
      bus.spike_out = '1;
      chk("abort_spike_en", 32'(bus.spike_en), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_count0", 32'(bus.spike_count[0 +: CW]), 32'd2);
      repeat (3) @(posedge clk);
      #1;
      bus.spike_out = '0;
      chk("abort_hold_count0", 32'(bus.spike_count[0 +: CW]), 32'd2);
      chk("abort_hold_count1", 32'(bus.spike_count[CW +: CW]), 32'd0);
      $display("[TB] abort at 5th RUN cycle checked");
      // restart after abort zeroes counts
      do_run(0, 4'b0100, 0, 0, 0, 0, 0, 0, 0);

      // asynchronous reset in the middle of RUN
      @(posedge clk); #1;
      run_id++;
      cur_mask       = 4'b1111;
      bus.start      = 1'b1;
      bus.timesteps  = CW'(10);
      bus.input_mask = 4'b1111;
      bus.spike_out  = '1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      chk("arst_spike_en", 32'(bus.spike_en), 32'd0);
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_net_clr", 32'(bus.net_clr), 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      chk("arst_counts", 32'(bus.spike_count), 32'd0);
      #2;
      rst_n = 1'b1;
      bus.spike_out = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("arst_idle_busy", 32'(bus.busy), 32'd0);
      chk("arst_idle_spike_en", 32'(bus.spike_en), 32'd0);
      $display("[TB] reset mid-run checked");
      // normal run after reset: odd-cycle spikes at k=3,5
      do_run(2, 4'b1001, 1, 0, 0, 2, 0, 0, 0);

      repeat (5) @(posedge clk);
      #1;
      chk("pending_done", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
